reg_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit write-register select mux (rt/rd choice); that mux output drives wr_addr here.
- Provides two combinational read ports (rs, rt) and one synchronous write port, plus a read-only debug port for board/bench observation.
- Register $0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_rdport.sv | 50 +++++
 rtl/reg_file.sv | 92 +++++++++
 tb/tb_reg_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the MIPS general-purpose register file and the
// write-register select logic upstream of it.
//   DATA_W   : register width
//   ADDR_W   : register index width
//   REG_ZERO : hardwired-zero register index
//   REG_RA   : jal link register index
//   REG_SP   : stack pointer register index
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_SP   = 5'd29;

endpackage : reg_file_pkg

// File: rtl/reg_file_rdport.sv
// -----------------------------------------------------------------------------
// reg_file_rdport
// One combinational read port of the register file. It selects a stored
// entry, optionally forwards the write data being presented this cycle, and
// forces zero for index 0 and while reset is asserted.
// Ports:
//   i_rst      : register-file reset (forces output to zero)
//   i_addr     : read index
//   i_we       : write enable of the write port (bypass qualifier)
//   i_wr_addr  : write index (bypass compare)
//   i_wr_data  : write data (bypass source)
//   i_regs     : storage view, entry 0 already tied to zero
//   o_data     : read data
// -----------------------------------------------------------------------------
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  output logic [DATA_W-1:0] o_data
);

  logic w_addr_zero;
  logic w_fwd;

  assign w_addr_zero = (i_addr == ADDR_W'(REG_ZERO));
  // Forward only a write that will actually land in storage.
  assign w_fwd = BYPASS && i_we && (i_wr_addr != ADDR_W'(REG_ZERO)) &&
                 (i_addr == i_wr_addr);

  always_comb begin
    o_data = i_regs[i_addr];
    if (w_fwd) begin
      o_data = i_wr_data;
    end
    // Reset must win over bypass so reads are zero throughout reset.
    if (i_rst || w_addr_zero) begin
      o_data = '0;
    end
  end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32 general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports (rs, rt), one synchronous write port and a
// read-only debug port. Register 0 reads as zero and has no storage.
// Ports:
//   clk      : clock, writes on rising edge
//   rst      : asynchronous active-high reset, clears all entries
//   we       : write enable (RegWrite)
//   wr_addr  : write index (from write-register select mux)
//   wr_data  : write data (from memtoreg/ALU result mux)
//   rs_addr  : read port A index      rs_data : read port A data
//   rt_addr  : read port B index      rt_data : read port B data
//   dbg_addr : debug read index       dbg_data: debug read data
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2**ADDR_W;

  // Entry 0 is a constant, so storage starts at index 1.
  logic [DATA_W-1:0] r_mem  [1:DEPTH-1];
  logic [DATA_W-1:0] w_regs [DEPTH];
  logic              w_wr_en;

  assign w_wr_en = we && (wr_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_regs[i] = r_mem[i];
    end
  end

  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_rs (
    .i_rst     (rst),
    .i_addr    (rs_addr),
    .i_we      (we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_regs    (w_regs),
    .o_data    (rs_data)
  );

  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_rt (
    .i_rst     (rst),
    .i_addr    (rt_addr),
    .i_we      (we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_regs    (w_regs),
    .o_data    (rt_data)
  );

  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_dbg (
    .i_rst     (rst),
    .i_addr    (dbg_addr),
    .i_we      (we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_regs    (w_regs),
    .o_data    (dbg_data)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Drives one BYPASS=0 and one BYPASS=1 register file with the same inputs.
// Stimulus pushes expected port values into a queue; a monitor on the falling
// clock edge pops and compares them against the live outputs.
// Port ids: 0..2 = rs/rt/dbg of the BYPASS=0 instance, 3..5 = BYPASS=1.
// -----------------------------------------------------------------------------
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs0, rt0, dbg0, rs1, rt1, dbg1;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs0), .rt_data(rt0),
    .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs1), .rt_data(rt1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t        q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model [32];

  // Monitor: compare every queued expectation against the current outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.port)
        0:       act = rs0;
        1:       act = rt0;
        2:       act = dbg0;
        3:       act = rs1;
        4:       act = rt1;
        default: act = dbg1;
      endcase
      n_total++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s port%0d: got %08h expected %08h", c.nm, c.port, act, c.exp);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // k: 0=rs 1=rt 2=dbg; e0/e1 are expectations for BYPASS=0 / BYPASS=1.
  task automatic expect2(input int k, input logic [31:0] e0, input logic [31:0] e1,
                         input string nm);
    q.push_back('{k, e0, nm});
    q.push_back('{k + 3, e1, nm});
  endtask

  task automatic expect_same(input int k, input logic [31:0] e, input string nm);
    expect2(k, e, e, nm);
  endtask

  task automatic dbg_sweep(input string nm);
    for (int i = 0; i < 32; i++) begin
      cyc();
      we = 1'b0;
      dbg_addr = 5'(i);
      expect_same(2, model[i], nm);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    cyc();
    rs_addr = 5'd5; rt_addr = 5'd31; dbg_addr = 5'd17;
    expect_same(0, 32'h0, "reset_rs");
    expect_same(1, 32'h0, "reset_rt");
    expect_same(2, 32'h0, "reset_dbg");
    cyc();
    rst = 1'b0;

    // Preload entries 1..31 with index*0x11111111
    for (int i = 1; i < 32; i++) begin
      cyc();
      we = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h11111111;
      model[i] = wr_data;
    end
    dbg_sweep("preload");

    // Reset pulse between edges: outputs zero at once, even with a bypassable write
    cyc();
    rst = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
    rs_addr = 5'd3; rt_addr = 5'd31; dbg_addr = 5'd17;
    expect_same(0, 32'h0, "rst_async_rs");
    expect_same(1, 32'h0, "rst_async_rt");
    expect_same(2, 32'h0, "rst_async_dbg");
    for (int i = 0; i < 32; i++) model[i] = '0;
    // Held reset with colliding writes on every index
    for (int i = 0; i < 32; i++) begin
      cyc();
      wr_addr = 5'(i); rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i);
      expect_same(0, 32'h0, "rst_hold_rs");
      expect_same(1, 32'h0, "rst_hold_rt");
      expect_same(2, 32'h0, "rst_hold_dbg");
    end
    cyc();
    rst = 1'b0; we = 1'b0;
    dbg_sweep("post_reset");

    // Reset collision on entry 3
    cyc();
    rst = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEBABE;
    cyc();
    rst = 1'b0; we = 1'b0; dbg_addr = 5'd3;
    expect_same(2, 32'h0, "collide_discard");
    cyc();
    we = 1'b1;
    expect2(2, 32'h0, 32'hCAFEBABE, "collide_rewrite_pre");
    cyc();
    we = 1'b0;
    expect_same(2, 32'hCAFEBABE, "collide_rewrite_post");
    model[3] = 32'hCAFEBABE;

    // Basic write/read on entry 8
    cyc();
    we = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF;
    rs_addr = 5'd8; rt_addr = 5'd8;
    expect2(0, 32'h0, 32'hDEADBEEF, "wr8_pre_rs");
    expect2(1, 32'h0, 32'hDEADBEEF, "wr8_pre_rt");
    cyc();
    we = 1'b0; dbg_addr = 5'd7;
    model[8] = 32'hDEADBEEF;
    expect_same(0, 32'hDEADBEEF, "wr8_rs");
    expect_same(1, 32'hDEADBEEF, "wr8_rt");
    expect_same(2, 32'h0, "wr8_e7");
    cyc();
    dbg_addr = 5'd9;
    expect_same(2, 32'h0, "wr8_e9");

    // Register 0 protection
    cyc();
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
    expect_same(0, 32'h0, "r0_pre_rs");
    expect_same(1, 32'h0, "r0_pre_rt");
    expect_same(2, 32'h0, "r0_pre_dbg");
    cyc();
    we = 1'b0;
    expect_same(0, 32'h0, "r0_post_rs");
    dbg_sweep("r0_sweep");

    // Write disable
    cyc();
    we = 1'b0; wr_addr = 5'd31; wr_data = 32'h12345678; rs_addr = 5'd31;
    expect_same(0, 32'h0, "we0_pre");
    cyc();
    expect_same(0, 32'h0, "we0_post");

    // Read during write on entry 10
    cyc();
    we = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA0000;
    cyc();
    wr_data = 32'h5555FFFF; rs_addr = 5'd10; rt_addr = 5'd8; dbg_addr = 5'd10;
    expect2(0, 32'hAAAA0000, 32'h5555FFFF, "rdw_pre_rs");
    expect_same(1, 32'hDEADBEEF, "rdw_pre_rt_other");
    expect2(2, 32'hAAAA0000, 32'h5555FFFF, "rdw_pre_dbg");
    cyc();
    we = 1'b0;
    model[10] = 32'h5555FFFF;
    expect_same(0, 32'h5555FFFF, "rdw_post_rs");
    expect_same(2, 32'h5555FFFF, "rdw_post_dbg");

    // Final state sweep
    dbg_sweep("final");

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file
